// File: rtl/uart_tx_arbiter.sv
// Round-robin frame arbiter sharing one UART TX FIFO write port among N byte-stream requesters.
// Whole frames are granted atomically, optionally led by a {tag, id} header byte and capped at MAX_LEN data bytes.
module uart_tx_arbiter #(
  parameter int         N       = 4,
  parameter int         DBIT    = 8,
  parameter bit         HDR_EN  = 1'b1,
  parameter logic [3:0] HDR_TAG = 4'hA,
  parameter int         MAX_LEN = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N-1:0]        req_valid,
  input  logic [N*DBIT-1:0]   req_data,
  input  logic [N-1:0]        req_last,
  output logic [N-1:0]        req_ready,
  input  logic                tx_full,
  output logic                wr_uart,
  output logic [DBIT-1:0]     w_data,
  output logic [N-1:0]        grant,
  output logic                busy,
  output logic                frame_trunc
);

  localparam int         IDW      = (N > 1) ? $clog2(N) : 1;
  localparam logic [7:0] LAST_LEN = 8'(MAX_LEN - 1);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t         state, state_next;
  logic [N-1:0]   grant_next;
  logic [IDW-1:0] id, id_next;
  logic [IDW-1:0] rr, rr_next;
  logic [7:0]     len, len_next;
  logic           trunc_next;

  logic           pick_found;
  logic [IDW-1:0] pick_id;
  int             idx;

  logic [DBIT-1:0] cur_data;
  logic            cur_valid;
  logic            cur_last;
  logic [7:0]      hdr_byte;

  assign cur_data  = req_data[id*DBIT +: DBIT];
  assign cur_valid = req_valid[id];
  assign cur_last  = req_last[id];
  assign hdr_byte  = {HDR_TAG, 4'(id)};
  assign busy      = (state != IDLE);

  // Search starts just past the last served requester so every requester gets a turn.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    idx        = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(rr) + k) % N;
      if (!pick_found && req_valid[idx]) begin
        pick_found = 1'b1;
        pick_id    = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_next = state;
    grant_next = grant;
    id_next    = id;
    rr_next    = rr;
    len_next   = len;
    trunc_next = 1'b0;
    wr_uart    = 1'b0;
    w_data     = '0;
    req_ready  = '0;
    unique case (state)
      IDLE: begin
        if (pick_found) begin
          grant_next = N'(1) << pick_id;
          id_next    = pick_id;
          len_next   = '0;
          state_next = HDR_EN ? HDR : DATA;
        end
      end
      HDR: begin
        wr_uart = !tx_full;
        w_data  = DBIT'(hdr_byte);
        if (!tx_full) state_next = DATA;
      end
      DATA: begin
        req_ready = grant & {N{!tx_full}};
        // A frame closes on the requester's last byte or when the length cap is reached.
        if (cur_valid && !tx_full) begin
          wr_uart  = 1'b1;
          w_data   = cur_data;
          len_next = len + 8'd1;
          if (cur_last || len == LAST_LEN) begin
            state_next = IDLE;
            grant_next = '0;
            rr_next    = id;
            trunc_next = !cur_last;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      grant       <= '0;
      id          <= '0;
      rr          <= IDW'(N - 1);
      len         <= '0;
      frame_trunc <= 1'b0;
    end else begin
      state       <= state_next;
      grant       <= grant_next;
      id          <= id_next;
      rr          <= rr_next;
      len         <= len_next;
      frame_trunc <= trunc_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized traffic, all checked against
// a queue-based frame model that predicts the written byte stream and the arbitration order.
module tb_uart_tx_arbiter;

  localparam int         N       = 4;
  localparam int         DBIT    = 8;
  localparam int         MAX_LEN = 4;
  localparam logic [3:0] TAG     = 4'hA;

  logic                clk = 1'b0;
  logic                reset;
  logic [N-1:0]        req_valid;
  logic [N*DBIT-1:0]   req_data;
  logic [N-1:0]        req_last;
  logic [N-1:0]        req_ready;
  logic                tx_full;
  logic                wr_uart;
  logic [DBIT-1:0]     w_data;
  logic [N-1:0]        grant;
  logic                busy;
  logic                frame_trunc;

  uart_tx_arbiter #(
    .N(N), .DBIT(DBIT), .HDR_EN(1'b1), .HDR_TAG(TAG), .MAX_LEN(MAX_LEN)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_full(tx_full),
    .wr_uart(wr_uart), .w_data(w_data), .grant(grant), .busy(busy),
    .frame_trunc(frame_trunc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Per-requester pending bytes, consumed on valid & ready.
  logic [7:0] src_data [N][$];
  bit         src_last [N][$];
  int         bubble_hold [N];
  int         full_hold;
  bit         rand_mode;
  int         trig_writes;
  int         trig_kind;
  int         trig_req;

  logic [7:0] wlog[$];
  int         wcyc[$];
  logic [7:0] ref_log[$];
  int         cycle;
  int         trunc_seen;

  // Frame-level reference: the expected write sequence of the frame currently granted.
  bit         m_active;
  bit         m_hdr;
  bit         m_cut;
  bit         m_closes;
  bit         m_trunc_due;
  int         m_owner;
  int         m_rr;
  logic [7:0] exp_q[$];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  task automatic model_reset();
    m_active    = 1'b0;
    m_hdr       = 1'b0;
    m_cut       = 1'b0;
    m_closes    = 1'b0;
    m_trunc_due = 1'b0;
    m_owner     = 0;
    m_rr        = N - 1;
    exp_q.delete();
  endtask

  // The frame is whatever the owner has queued up to its last byte, capped at MAX_LEN bytes.
  task automatic build_frame(input int o);
    int cnt;
    cnt = 0;
    exp_q.delete();
    exp_q.push_back({TAG, 4'(o)});
    m_cut    = 1'b0;
    m_closes = 1'b0;
    for (int j = 0; j < src_data[o].size(); j++) begin
      exp_q.push_back(src_data[o][j]);
      cnt++;
      if (src_last[o][j]) begin
        m_closes = 1'b1;
        break;
      end
      if (cnt == MAX_LEN) begin
        m_closes = 1'b1;
        m_cut    = 1'b1;
        break;
      end
    end
    m_owner  = o;
    m_active = 1'b1;
    m_hdr    = 1'b1;
  endtask

  task automatic push_frame(input int r, input int n, input logic [7:0] base, input bit last_end);
    for (int b = 0; b < n; b++) begin
      src_data[r].push_back(base + 8'(b));
      src_last[r].push_back(last_end && (b == n - 1));
    end
  endtask

  task automatic drive_inputs();
    bit v;
    for (int i = 0; i < N; i++) begin
      v = (src_data[i].size() > 0) && (bubble_hold[i] == 0) &&
          !(rand_mode && $urandom_range(0, 3) == 0);
      req_valid[i]          = v;
      req_data[i*DBIT +: 8] = (src_data[i].size() > 0) ? src_data[i][0] : 8'h00;
      req_last[i]           = (src_data[i].size() > 0) ? src_last[i][0] : 1'b0;
    end
    tx_full = (full_hold > 0) || (rand_mode && $urandom_range(0, 3) == 0);
  endtask

  // One clock: drive, check against the model, then advance requesters and model on the edge.
  task automatic applyStimulus();
    bit         e_wr;
    bit         found;
    int         cand;
    logic [N-1:0] e_ready;
    logic [N-1:0] rdy;
    logic [N-1:0] vld;
    logic       wr_s;
    logic [7:0] wd_s;
    logic [7:0] exp_d;
    @(negedge clk);
    cycle++;
    drive_inputs();
    #1;
    e_ready = (m_active && !m_hdr && !tx_full) ? (N'(1) << m_owner) : '0;
    e_wr    = m_active && !tx_full && (m_hdr || req_valid[m_owner]);
    exp_d   = (exp_q.size() > 0) ? exp_q[0] : 8'h00;
    checkOutput("busy", busy, m_active);
    checkOutput("grant", grant, m_active ? (N'(1) << m_owner) : '0);
    checkOutput("frame_trunc", frame_trunc, m_trunc_due);
    checkOutput("req_ready", req_ready, e_ready);
    checkOutput("wr_uart", wr_uart, e_wr);
    if (e_wr && wr_uart) checkOutput("w_data", w_data, exp_d);
    if (frame_trunc) trunc_seen++;
    rdy  = req_ready;
    vld  = req_valid;
    wr_s = wr_uart;
    wd_s = w_data;
    @(posedge clk);
    if (wr_s) begin
      wlog.push_back(wd_s);
      wcyc.push_back(cycle);
    end
    m_trunc_due = 1'b0;
    if (m_active) begin
      if (e_wr) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        m_hdr = 1'b0;
        if (exp_q.size() == 0 && m_closes) begin
          m_active    = 1'b0;
          m_rr        = m_owner;
          m_trunc_due = m_cut;
        end
      end
    end else begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        cand = (m_rr + k) % N;
        if (!found && vld[cand]) begin
          found = 1'b1;
          build_frame(cand);
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (vld[i] && rdy[i] && src_data[i].size() > 0) begin
        void'(src_data[i].pop_front());
        void'(src_last[i].pop_front());
      end
      if (bubble_hold[i] > 0) bubble_hold[i]--;
    end
    if (full_hold > 0) full_hold--;
    if (trig_writes > 0 && wlog.size() == trig_writes) begin
      if (trig_kind == 0) full_hold = 5;
      else bubble_hold[trig_req] = 3;
      trig_writes = 0;
    end
  endtask

  function automatic bit all_drained();
    bit d;
    d = !m_active;
    for (int i = 0; i < N; i++) if (src_data[i].size() != 0) d = 1'b0;
    return d;
  endfunction

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while (!all_drained() && n < budget) begin
      applyStimulus();
      n++;
    end
    if (!all_drained()) checkOutput("drain_timeout", 32'(n), 32'(budget + 1));
    applyStimulus();
    applyStimulus();
  endtask

  task automatic run_until_writes(input int count, input int budget);
    int n;
    n = 0;
    while (wlog.size() < count && n < budget) begin
      applyStimulus();
      n++;
    end
    if (wlog.size() < count) checkOutput("write_timeout", 32'(wlog.size()), 32'(count));
  endtask

  task automatic compare_log(input string tag);
    checkOutput({tag, "_count"}, 32'(wlog.size()), 32'(ref_log.size()));
    for (int i = 0; i < wlog.size() && i < ref_log.size(); i++)
      checkOutput(tag, wlog[i], ref_log[i]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      src_data[i].delete();
      src_last[i].delete();
      bubble_hold[i] = 0;
    end
    full_hold   = 0;
    trig_writes = 0;
    req_valid   = '0;
    req_data    = '0;
    req_last    = '0;
    tx_full     = 1'b0;
    model_reset();
    #1;
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_grant", grant, '0);
    checkOutput("rst_wr_uart", wr_uart, 1'b0);
    checkOutput("rst_req_ready", req_ready, '0);
    checkOutput("rst_frame_trunc", frame_trunc, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    wlog.delete();
    wcyc.delete();
    trunc_seen = 0;
  endtask

  initial begin
    int start_cyc;
    reset       = 1'b0;
    req_valid   = '0;
    req_data    = '0;
    req_last    = '0;
    tx_full     = 1'b0;
    rand_mode   = 1'b0;
    cycle       = 0;
    full_hold   = 0;
    trig_writes = 0;
    trig_kind   = 0;
    trig_req    = 0;
    for (int i = 0; i < N; i++) bubble_hold[i] = 0;

    // Single three-byte frame from requester 0.
    do_reset();
    push_frame(0, 3, 8'hA1, 1'b1);
    start_cyc = cycle + 1;
    run_until_idle(50);
    ref_log = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    compare_log("single");
    if (wcyc.size() == 4) begin
      checkOutput("single_latency", 32'(wcyc[0] - start_cyc), 32'd1);
      checkOutput("single_back2back", 32'(wcyc[3] - wcyc[0]), 32'd3);
    end

    // All four requesters at once, requester 0 queues a second frame.
    do_reset();
    for (int i = 0; i < N; i++) push_frame(i, 1, 8'h10 + 8'(i), 1'b1);
    push_frame(0, 1, 8'h20, 1'b1);
    run_until_idle(100);
    ref_log = '{8'hA0, 8'h10, 8'hA1, 8'h11, 8'hA2, 8'h12, 8'hA3, 8'h13, 8'hA0, 8'h20};
    compare_log("contention");

    // FIFO full for five cycles after the second data byte.
    do_reset();
    push_frame(0, 4, 8'h31, 1'b1);
    trig_writes = 3;
    trig_kind   = 0;
    run_until_idle(100);
    ref_log = '{8'hA0, 8'h31, 8'h32, 8'h33, 8'h34};
    compare_log("backpressure");
    if (wcyc.size() == 5) checkOutput("backpressure_gap", 32'(wcyc[3] - wcyc[2]), 32'd6);

    // Requester 2 bubbles mid-frame while requester 3 waits.
    do_reset();
    push_frame(2, 4, 8'h41, 1'b1);
    push_frame(3, 1, 8'h51, 1'b1);
    trig_writes = 3;
    trig_kind   = 1;
    trig_req    = 2;
    run_until_idle(100);
    ref_log = '{8'hA2, 8'h41, 8'h42, 8'h43, 8'h44, 8'hA3, 8'h51};
    compare_log("bubble");

    // Six bytes without a last flag are cut at MAX_LEN and resume under a new header.
    do_reset();
    push_frame(1, 6, 8'h01, 1'b0);
    run_until_writes(8, 100);
    applyStimulus();
    applyStimulus();
    ref_log = '{8'hA1, 8'h01, 8'h02, 8'h03, 8'h04, 8'hA1, 8'h05, 8'h06};
    compare_log("trunc");
    checkOutput("trunc_pulses", 32'(trunc_seen), 32'd1);

    // Reset lands while a data byte is being written.
    do_reset();
    push_frame(2, 4, 8'h61, 1'b1);
    run_until_writes(3, 50);
    @(negedge clk);
    drive_inputs();
    tx_full = 1'b0;
    #1;
    checkOutput("pre_reset_wr", wr_uart, 1'b1);
    reset = 1'b0;
    #1;
    checkOutput("midrst_wr_uart", wr_uart, 1'b0);
    checkOutput("midrst_grant", grant, '0);
    checkOutput("midrst_busy", busy, 1'b0);
    checkOutput("midrst_req_ready", req_ready, '0);
    do_reset();
    push_frame(3, 1, 8'h72, 1'b1);
    push_frame(0, 1, 8'h71, 1'b1);
    run_until_idle(50);
    ref_log = '{8'hA0, 8'h71, 8'hA3, 8'h72};
    compare_log("after_reset");

    // Randomized traffic: random frame lengths (some over MAX_LEN), bubbles and FIFO stalls.
    rand_mode = 1'b1;
    for (int round = 0; round < 4; round++) begin
      do_reset();
      for (int f = 0; f < 20; f++)
        push_frame($urandom_range(0, N - 1), $urandom_range(1, 7), 8'($urandom_range(0, 255)), 1'b1);
      run_until_idle(5000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
